vga_scan_generator: RTL
=======================

# vga_scan_generator

Produces the raster scan that drives the display path: free-running horizontal/vertical counters, active-low HS/VS, blanking, and the DrawX/DrawY pixel coordinates consumed by the sprite and tile lookup logic, plus tile-grid coordinates for 8x16 cells. It sits between the clock/pixel-enable source and every block that indexes by screen position. All outputs are registered and mutually aligned.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- Clk  in  1  system clock. One clock domain; reset is asynchronous and active-low.
- Reset_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel-clock enable; the scan advances only on Clk edges with pix_ce=1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank_n  out  1  1 inside the visible region, 0 otherwise
- DrawX  out  10  current horizontal position (0..H_TOTAL-1)
- DrawY  out  10  current vertical position (0..V_TOTAL-1)
- tile_col  out  7  DrawX[9:3], 8-pixel-wide cell column
- tile_row  out  6  DrawY[9:4], 16-line-tall cell row
- line_start  out  1  single-Clk pulse when DrawX becomes 0
- frame_start  out  1  single-Clk pulse when (DrawX,DrawY) becomes (0,0)

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024. Violation is an elaboration error.
- The internal hcnt counts 0..H_TOTAL-1 on each pix_ce, then wraps to 0. The internal vcnt increments when hcnt wraps, and wraps to 0 after V_TOTAL-1.
- The output stage registers decoded values of (hcnt, vcnt) on pix_ce:
  - DrawX=hcnt, DrawY=vcnt.
  - hs=0 when H_VISIBLE+H_FRONT ≤ hcnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs=0 when V_VISIBLE+V_FRONT ≤ vcnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - blank_n=1 when hcnt<H_VISIBLE and vcnt<V_VISIBLE.
  - tile_col and tile_row are always the bit slices of DrawX and DrawY.
- Pulses:
  - line_start=1 for exactly one Clk cycle, on the cycle where DrawX is loaded with 0.
  - frame_start is the same, additionally requiring DrawY=0.
  - Both are 0 on every cycle with pix_ce=0.
- pix_ce held low: all counters and level outputs hold, and the pulses stay 0.
- Reset values (async assert, any time, including mid-frame):
  - hcnt=0, vcnt=0, DrawX=0, DrawY=0, tile_col=0, tile_row=0
  - hs=1, vs=1, blank_n=0, line_start=0, frame_start=0
- After Reset_n deasserts, the first pix_ce loads position (0,0), which asserts blank_n=1, line_start=1 and frame_start=1. The scan is then deterministic from that origin.

## Timing
- Latency: each output reflects the counter state one pix_ce earlier. All outputs share this latency, so hs, vs, blank_n and DrawX/DrawY are cycle-aligned.
- One visible pixel per pix_ce. Line period is H_TOTAL pix_ce events; frame period is H_TOTAL*V_TOTAL (420000).
- Wrap: DrawX 799 -> 0 and DrawY increments in the same update. DrawX 799 with DrawY 524 -> (0,0), with line_start and frame_start both pulsing.
- Sync edges are exact:
  - hs falls when DrawX becomes 656 and rises when DrawX becomes 752.
  - vs falls when DrawY becomes 490 and rises when DrawY becomes 492; vs edges coincide with the DrawX 799->0 update.
- Reset_n deassertion is synchronized internally with a 2-flop release so the scan never starts on a metastable edge. Outputs stay at reset values until the first pix_ce after release.

## Structure
- Package vga_timing_pkg:
  - default timing constants (H_VISIBLE..V_BACK, derived H_TOTAL/V_TOTAL)
  - TILE_W_LOG2=3, TILE_H_LOG2=4
  - typedef for the 10-bit screen coordinate
- One sub-module, scan_counter: parameterized modulus, with enable, wrap-pulse output and async active-low clear. It is instantiated twice: horizontal with enable pix_ce, vertical with enable pix_ce & h_wrap.

## Test plan
- Reset, then continuous pix_ce=1: the first update gives DrawX=0, DrawY=0, blank_n=1, frame_start=1. Exactly 420000 pix_ce later frame_start pulses again.
- One full line: hs=0 for exactly 96 pix_ce, from DrawX=656 through 751. blank_n=0 from DrawX=640 through 799. line_start pulses at 800-pix_ce intervals.
- Full frame: vs=0 for exactly 2 lines (DrawY 490, 491), i.e. 1600 pix_ce. blank_n is never 1 for DrawY ≥ 480.
- pix_ce toggling 1/0 (50 MHz Clk, 25 MHz pixel rate): outputs change only on enabled edges, and each pulse is 1 Clk wide. Freezing pix_ce low for 100 cycles at DrawX=300 holds DrawX=300.
- Tile mapping: at DrawX=647 and DrawY=479, tile_col=80 and tile_row=29. At DrawX=8 and DrawY=16, tile_col=1 and tile_row=1.
- Assert Reset_n mid-frame at DrawX=400, DrawY=250: all outputs go immediately to reset values. After release, the scan restarts at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : default 640x480 raster timing, tile geometry, coordinate type
// Revision       : 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int COORD_W     = 10;
  localparam int COORD_MAX   = 1 << COORD_W;
  localparam int TILE_W_LOG2 = 3;
  localparam int TILE_H_LOG2 = 4;

  typedef logic [COORD_W-1:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/scan_counter.sv
`default_nettype none
// ============================================================================
// scan_counter : modulo-N enabled counter with wrap pulse and async clear
// Revision     : 1.0
// ============================================================================
module scan_counter
  import vga_timing_pkg::*;
#(
  parameter int MODULUS = DEF_H_TOTAL
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  output coord_t count_o,
  output logic   wrap_o
);

  localparam coord_t c_last = coord_t'(MODULUS - 1);

  coord_t count_q;
  coord_t count_d;

  assign wrap_o  = en_i && (count_q == c_last);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == c_last) ? '0 : count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_scan_generator.sv
`default_nettype none
// ============================================================================
// vga_scan_generator : raster counters with registered, aligned sync/blank/
//                      coordinate/tile outputs and line/frame start pulses
// Revision           : 1.0
// ============================================================================
module vga_scan_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            pix_ce,
  output logic                            hs,
  output logic                            vs,
  output logic                            blank_n,
  output coord_t                          DrawX,
  output coord_t                          DrawY,
  output logic [COORD_W-TILE_W_LOG2-1:0]  tile_col,
  output logic [COORD_W-TILE_H_LOG2-1:0]  tile_row,
  output logic                            line_start,
  output logic                            frame_start
);

  localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t c_hs_start  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t c_hs_end    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t c_vs_start  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t c_vs_end    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t c_h_visible = coord_t'(H_VISIBLE);
  localparam coord_t c_v_visible = coord_t'(V_VISIBLE);

  if (c_h_total > COORD_MAX) begin : g_h_total_check
    $error("vga_scan_generator: horizontal total exceeds 1024");
  end
  if (c_v_total > COORD_MAX) begin : g_v_total_check
    $error("vga_scan_generator: vertical total exceeds 1024");
  end

  // Assert asynchronously, release two Clk edges after Reset_n rises.
  logic [1:0] rst_sync_q;
  logic       w_rst_n;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign w_rst_n = rst_sync_q[1];

  coord_t w_hcnt;
  coord_t w_vcnt;
  logic   w_h_wrap;
  logic   w_v_en;
  logic   w_v_wrap_unused;

  assign w_v_en = pix_ce & w_h_wrap;

  scan_counter #(.MODULUS(c_h_total)) u_hcnt (
    .clk_i   (Clk),
    .rst_ni  (w_rst_n),
    .en_i    (pix_ce),
    .count_o (w_hcnt),
    .wrap_o  (w_h_wrap)
  );

  scan_counter #(.MODULUS(c_v_total)) u_vcnt (
    .clk_i   (Clk),
    .rst_ni  (w_rst_n),
    .en_i    (w_v_en),
    .count_o (w_vcnt),
    .wrap_o  (w_v_wrap_unused)
  );

  coord_t drawx_q, drawx_d;
  coord_t drawy_q, drawy_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   blank_n_q, blank_n_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;

  // Every output samples the same counter state, keeping them cycle-aligned.
  always_comb begin
    drawx_d       = drawx_q;
    drawy_d       = drawy_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      drawx_d       = w_hcnt;
      drawy_d       = w_vcnt;
      hs_d          = !((w_hcnt >= c_hs_start) && (w_hcnt < c_hs_end));
      vs_d          = !((w_vcnt >= c_vs_start) && (w_vcnt < c_vs_end));
      blank_n_d     = (w_hcnt < c_h_visible) && (w_vcnt < c_v_visible);
      line_start_d  = (w_hcnt == '0);
      frame_start_d = (w_hcnt == '0) && (w_vcnt == '0);
    end
  end

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      drawx_q       <= '0;
      drawy_q       <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      drawx_q       <= drawx_d;
      drawy_q       <= drawy_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank_n     = blank_n_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign tile_col    = drawx_q[COORD_W-1:TILE_W_LOG2];
  assign tile_row    = drawy_q[COORD_W-1:TILE_H_LOG2];

endmodule
`default_nettype wire
